connect_n_engine: RTL and testbench

Parametrised game engine for the connect-N family: owns the board, cursor, turn and end-of-game detection for any column/row count, win length and player count. Generalises the fixed 7x6, 2-player, win-4 game: it adds a sequential win scanner around the last placed piece, N-player rotation, cursor wrap mode, a new-game clear, and a read port for the display block. It sits between the button front end and the VGA renderer.

---
 rtl/connect_n_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_connect_n_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_n_engine.sv
// connect_n_engine
//   Game engine for the connect-N family. It holds the board, the per-column
//   fill heights, the cursor, whose turn it is and the end-of-game state.
//   After every accepted drop a sequential scanner walks outward from the new
//   piece, one cell per cycle, in four directions looking for WIN_LEN in a row.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   left, right, put      level buttons, acted on at their rising edge
//   new_game              synchronous board clear (level, any state)
//   rd_col, rd_row        display read address (row 0 = bottom)
//   rd_cell               combinational cell content, 0 empty / p+1 player p
//   cursor, player        selected column, player to move
//   busy                  high while the scanner runs
//   invalid_move          last put hit a full column (level)
//   win, winner           game won and by whom
//   win_col, win_row      anchor of the winning line (the last piece placed)
//   win_dir               0 horiz, 1 vert, 2 diag up-right, 3 diag down-right
//   full_panel            board full without a winner
module connect_n_engine #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int PLAYERS = 2,
    parameter int WRAP    = 0,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int PW = $clog2(PLAYERS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left,
    input  logic          right,
    input  logic          put,
    input  logic          new_game,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [PW-1:0] rd_cell,
    output logic [CW-1:0] cursor,
    output logic [PW-1:0] player,
    output logic          busy,
    output logic          invalid_move,
    output logic          win,
    output logic [PW-1:0] winner,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic [1:0]    win_dir,
    output logic          full_panel
);

    localparam int KW = $clog2(WIN_LEN + 1);
    localparam int HW = $clog2(ROWS + 1);
    localparam int NW = $clog2(COLS * ROWS + 1);
    // Signed probe coordinates need room for anchor +/- (WIN_LEN-1).
    localparam int SW = ((CW > RW) ? CW : RW) + 2;

    localparam logic [KW-1:0]        WIN_K       = KW'(WIN_LEN);
    localparam logic [KW-1:0]        LAST_STEP   = KW'(WIN_LEN - 1);
    localparam logic [KW-1:0]        ONE_K       = KW'(1);
    localparam logic [HW-1:0]        ROWS_H      = HW'(ROWS);
    localparam logic [NW-1:0]        CELLS_N     = NW'(COLS * ROWS);
    localparam logic [CW-1:0]        LAST_COL    = CW'(COLS - 1);
    localparam logic [PW-1:0]        LAST_PLAYER = PW'(PLAYERS - 1);
    localparam logic signed [SW-1:0] COLS_S      = $signed(SW'(COLS));
    localparam logic signed [SW-1:0] ROWS_S      = $signed(SW'(ROWS));
    localparam logic [CW:0]          COLS_RD     = (CW + 1)'(COLS);
    localparam logic [RW:0]          ROWS_RD     = (RW + 1)'(ROWS);
    localparam bit                   WRAP_EN     = (WRAP != 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] board_q  [COLS][ROWS];
    logic [PW-1:0] board_d  [COLS][ROWS];
    logic [HW-1:0] height_q [COLS];
    logic [HW-1:0] height_d [COLS];
    logic [NW-1:0] pieces_q, pieces_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [PW-1:0] player_q, player_d;
    logic          busy_q, busy_d;
    logic          inv_q, inv_d;
    logic          win_q, win_d;
    logic [PW-1:0] winner_q, winner_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [1:0]    win_dir_q, win_dir_d;
    logic          full_q, full_d;
    logic [CW-1:0] anchor_col_q, anchor_col_d;
    logic [RW-1:0] anchor_row_q, anchor_row_d;
    logic [1:0]    dir_q, dir_d;
    logic          fwd_q, fwd_d;
    logic [KW-1:0] step_q, step_d;
    logic [KW-1:0] count_q, count_d;
    logic [2:0]    btn_q, btn_d;

    logic                 left_edge_s, right_edge_s, put_edge_s;
    logic [RW-1:0]        drop_row_s;
    logic signed [SW-1:0] step_ext_s, dc_s, dr_s, pc_s, pr_s;
    logic                 probe_in_s;
    logic [CW-1:0]        probe_col_s;
    logic [RW-1:0]        probe_row_s;
    logic [PW-1:0]        probe_val_s;
    logic [PW-1:0]        piece_s;
    logic                 hit_s;

    // Button history and rising-edge detection; history tracks in every state
    // so a button held through CHECK does not fire when IDLE returns.
    always_comb begin
        btn_d        = {left, right, put};
        left_edge_s  = left  & ~btn_q[2];
        right_edge_s = right & ~btn_q[1];
        put_edge_s   = put   & ~btn_q[0];
        drop_row_s   = height_q[cursor_q][RW-1:0];
        piece_s      = player_q + PW'(1);
    end

    // Scanner probe: anchor offset by step along the current direction/side.
    always_comb begin
        step_ext_s = $signed(SW'(step_q));
        case (dir_q)
            2'd0: begin dc_s = step_ext_s;    dr_s = {SW{1'b0}};  end
            2'd1: begin dc_s = {SW{1'b0}};    dr_s = step_ext_s;  end
            2'd2: begin dc_s = step_ext_s;    dr_s = step_ext_s;  end
            2'd3: begin dc_s = step_ext_s;    dr_s = -step_ext_s; end
            default: begin dc_s = {SW{1'b0}}; dr_s = {SW{1'b0}};  end
        endcase
        if (!fwd_q) begin
            dc_s = -dc_s;
            dr_s = -dr_s;
        end else begin
            dc_s = dc_s;
            dr_s = dr_s;
        end
        pc_s = $signed(SW'(anchor_col_q)) + dc_s;
        pr_s = $signed(SW'(anchor_row_q)) + dr_s;
        probe_in_s = !pc_s[SW-1] && (pc_s < COLS_S) && !pr_s[SW-1] && (pr_s < ROWS_S);
        if (probe_in_s) begin
            probe_col_s = pc_s[CW-1:0];
            probe_row_s = pr_s[RW-1:0];
        end else begin
            probe_col_s = {CW{1'b0}};
            probe_row_s = {RW{1'b0}};
        end
        probe_val_s = board_q[probe_col_s][probe_row_s];
        hit_s       = probe_in_s && (probe_val_s == piece_s);
    end

    // Game FSM: new_game clear, move/drop handling in IDLE, win scan in CHECK.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        height_d     = height_q;
        pieces_d     = pieces_q;
        cursor_d     = cursor_q;
        player_d     = player_q;
        inv_d        = inv_q;
        win_d        = win_q;
        winner_d     = winner_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        win_dir_d    = win_dir_q;
        full_d       = full_q;
        anchor_col_d = anchor_col_q;
        anchor_row_d = anchor_row_q;
        dir_d        = dir_q;
        fwd_d        = fwd_q;
        step_d       = step_q;
        count_d      = count_q;

        if (new_game) begin
            for (int c = 0; c < COLS; c++) begin
                height_d[c] = {HW{1'b0}};
                for (int r = 0; r < ROWS; r++) begin
                    board_d[c][r] = {PW{1'b0}};
                end
            end
            state_d      = ST_IDLE;
            pieces_d     = {NW{1'b0}};
            cursor_d     = {CW{1'b0}};
            player_d     = {PW{1'b0}};
            inv_d        = 1'b0;
            win_d        = 1'b0;
            winner_d     = {PW{1'b0}};
            win_col_d    = {CW{1'b0}};
            win_row_d    = {RW{1'b0}};
            win_dir_d    = 2'd0;
            full_d       = 1'b0;
            anchor_col_d = {CW{1'b0}};
            anchor_row_d = {RW{1'b0}};
            dir_d        = 2'd0;
            fwd_d        = 1'b0;
            step_d       = {KW{1'b0}};
            count_d      = {KW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (put_edge_s) begin
                        // put wins over a simultaneous move; the move is lost
                        if (height_q[cursor_q] < ROWS_H) begin
                            board_d[cursor_q][drop_row_s] = piece_s;
                            height_d[cursor_q] = height_q[cursor_q] + HW'(1);
                            pieces_d     = pieces_q + NW'(1);
                            inv_d        = 1'b0;
                            anchor_col_d = cursor_q;
                            anchor_row_d = drop_row_s;
                            dir_d        = 2'd0;
                            fwd_d        = 1'b1;
                            step_d       = ONE_K;
                            count_d      = ONE_K;
                            state_d      = ST_CHECK;
                        end else begin
                            inv_d = 1'b1;
                        end
                    end else if (left_edge_s ^ right_edge_s) begin
                        inv_d = 1'b0;
                        if (left_edge_s) begin
                            if (cursor_q == {CW{1'b0}}) begin
                                cursor_d = WRAP_EN ? LAST_COL : cursor_q;
                            end else begin
                                cursor_d = cursor_q - CW'(1);
                            end
                        end else begin
                            if (cursor_q == LAST_COL) begin
                                cursor_d = WRAP_EN ? {CW{1'b0}} : cursor_q;
                            end else begin
                                cursor_d = cursor_q + CW'(1);
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (hit_s && ((count_q + ONE_K) == WIN_K)) begin
                        win_d     = 1'b1;
                        winner_d  = player_q;
                        win_dir_d = dir_q;
                        win_col_d = anchor_col_q;
                        win_row_d = anchor_row_q;
                        state_d   = ST_DONE;
                    end else begin
                        if (hit_s) begin
                            count_d = count_q + ONE_K;
                        end else begin
                            count_d = count_q;
                        end
                        if (hit_s && (step_q != LAST_STEP)) begin
                            step_d = step_q + ONE_K;
                        end else begin
                            // this side is finished: mismatch, edge or max reach
                            step_d = ONE_K;
                            if (fwd_q) begin
                                fwd_d = 1'b0;
                            end else if (dir_q != 2'd3) begin
                                dir_d   = dir_q + 2'd1;
                                fwd_d   = 1'b1;
                                count_d = ONE_K;
                            end else if (pieces_q == CELLS_N) begin
                                full_d  = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                player_d = (player_q == LAST_PLAYER) ? {PW{1'b0}}
                                                                     : player_q + PW'(1);
                                state_d  = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_CHECK);
    end

    // State and board registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= {HW{1'b0}};
                for (int r = 0; r < ROWS; r++) begin
                    board_q[c][r] <= {PW{1'b0}};
                end
            end
            state_q      <= ST_IDLE;
            pieces_q     <= {NW{1'b0}};
            cursor_q     <= {CW{1'b0}};
            player_q     <= {PW{1'b0}};
            busy_q       <= 1'b0;
            inv_q        <= 1'b0;
            win_q        <= 1'b0;
            winner_q     <= {PW{1'b0}};
            win_col_q    <= {CW{1'b0}};
            win_row_q    <= {RW{1'b0}};
            win_dir_q    <= 2'd0;
            full_q       <= 1'b0;
            anchor_col_q <= {CW{1'b0}};
            anchor_row_q <= {RW{1'b0}};
            dir_q        <= 2'd0;
            fwd_q        <= 1'b0;
            step_q       <= {KW{1'b0}};
            count_q      <= {KW{1'b0}};
            btn_q        <= 3'b000;
        end else begin
            board_q      <= board_d;
            height_q     <= height_d;
            state_q      <= state_d;
            pieces_q     <= pieces_d;
            cursor_q     <= cursor_d;
            player_q     <= player_d;
            busy_q       <= busy_d;
            inv_q        <= inv_d;
            win_q        <= win_d;
            winner_q     <= winner_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            win_dir_q    <= win_dir_d;
            full_q       <= full_d;
            anchor_col_q <= anchor_col_d;
            anchor_row_q <= anchor_row_d;
            dir_q        <= dir_d;
            fwd_q        <= fwd_d;
            step_q       <= step_d;
            count_q      <= count_d;
            btn_q        <= btn_d;
        end
    end

    // Display read port; addresses past the board read as empty.
    always_comb begin
        if (({1'b0, rd_col} < COLS_RD) && ({1'b0, rd_row} < ROWS_RD)) begin
            rd_cell = board_q[rd_col][rd_row];
        end else begin
            rd_cell = {PW{1'b0}};
        end
    end

    assign cursor       = cursor_q;
    assign player       = player_q;
    assign busy         = busy_q;
    assign invalid_move = inv_q;
    assign win          = win_q;
    assign winner       = winner_q;
    assign win_col      = win_col_q;
    assign win_row      = win_row_q;
    assign win_dir      = win_dir_q;
    assign full_panel   = full_q;

endmodule

// File: tb/tb_connect_n_engine.sv
// Bench for connect_n_engine: dut_a is the default 7x6/2-player/saturating
// build, dut_b a 3-player wrapping build. Both share stimulus; expectations
// are queued as stimulus is applied and compared once the engines settle.
module tb_connect_n_engine;

    logic       clk = 1'b0;
    logic       rst, left, right, put, new_game;
    logic [2:0] rd_col, rd_row;

    logic [1:0] a_rd_cell, a_player, a_winner, a_win_dir;
    logic [2:0] a_cursor, a_win_col, a_win_row;
    logic       a_busy, a_inv, a_win, a_full;
    logic [1:0] b_rd_cell, b_player, b_winner, b_win_dir;
    logic [2:0] b_cursor, b_win_col, b_win_row;
    logic       b_busy, b_inv, b_win, b_full;

    always #5 clk = ~clk;

    connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .PLAYERS(2), .WRAP(0)) dut_a (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .new_game(new_game), .rd_col(rd_col), .rd_row(rd_row), .rd_cell(a_rd_cell),
        .cursor(a_cursor), .player(a_player), .busy(a_busy), .invalid_move(a_inv),
        .win(a_win), .winner(a_winner), .win_col(a_win_col), .win_row(a_win_row),
        .win_dir(a_win_dir), .full_panel(a_full)
    );

    connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .PLAYERS(3), .WRAP(1)) dut_b (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .new_game(new_game), .rd_col(rd_col), .rd_row(rd_row), .rd_cell(b_rd_cell),
        .cursor(b_cursor), .player(b_player), .busy(b_busy), .invalid_move(b_inv),
        .win(b_win), .winner(b_winner), .win_col(b_win_col), .win_row(b_win_row),
        .win_dir(b_win_dir), .full_panel(b_full)
    );

    typedef enum int {
        S_CUR_A, S_CUR_B, S_PLY_A, S_PLY_B, S_BUSY_A, S_INV_A, S_WIN_A, S_WNR_A,
        S_DIR_A, S_WCOL_A, S_WROW_A, S_FULL_A, S_WIN_B, S_WNR_B, S_DIR_B,
        S_CELL_A, S_CELL_B, S_LAT_A
    } sel_t;

    typedef struct {
        string tag;
        sel_t  sel;
        int    col;
        int    row;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;
    int   lat_a = 0;
    int   seq[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void expect_v(input string tag, input sel_t sel, input int exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.col = 0; e.row = 0; e.exp = exp;
        sb.push_back(e);
    endfunction

    function automatic void expect_cell(input string tag, input sel_t sel,
                                        input int col, input int row, input int exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.col = col; e.row = row; e.exp = exp;
        sb.push_back(e);
    endfunction

    task automatic drain();
        exp_t e;
        int   got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_CUR_A:  got = int'(a_cursor);
                S_CUR_B:  got = int'(b_cursor);
                S_PLY_A:  got = int'(a_player);
                S_PLY_B:  got = int'(b_player);
                S_BUSY_A: got = int'(a_busy);
                S_INV_A:  got = int'(a_inv);
                S_WIN_A:  got = int'(a_win);
                S_WNR_A:  got = int'(a_winner);
                S_DIR_A:  got = int'(a_win_dir);
                S_WCOL_A: got = int'(a_win_col);
                S_WROW_A: got = int'(a_win_row);
                S_FULL_A: got = int'(a_full);
                S_WIN_B:  got = int'(b_win);
                S_WNR_B:  got = int'(b_winner);
                S_DIR_B:  got = int'(b_win_dir);
                S_LAT_A:  got = lat_a;
                S_CELL_A, S_CELL_B: begin
                    @(negedge clk);
                    rd_col = e.col[2:0];
                    rd_row = e.row[2:0];
                    #1;
                    got = (e.sel == S_CELL_A) ? int'(a_rd_cell) : int'(b_rd_cell);
                end
                default:  got = -1;
            endcase
            check_eq(e.tag, got, e.exp);
        end
    endtask

    // One button press, then wait (bounded) for both scanners to go idle.
    task automatic press(input logic l, input logic r, input logic p);
        int n;
        @(negedge clk);
        left = l; right = r; put = p;
        @(negedge clk);
        left = 1'b0; right = 1'b0; put = 1'b0;
        n = 0;
        lat_a = 0;
        while ((a_busy || b_busy) && n < 64) begin
            if (a_busy) lat_a++;
            n++;
            @(negedge clk);
        end
        if (n >= 64) check_eq("busy_timeout", n, 0);
    endtask

    task automatic goto_col(input int target);
        while (cur < target) begin press(1'b0, 1'b1, 1'b0); cur++; end
        while (cur > target) begin press(1'b1, 1'b0, 1'b0); cur--; end
    endtask

    task automatic put_at(input int col);
        goto_col(col);
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        cur = 0;
    endtask

    // Colour map of a drawn 7x6 board (runs of at most two in every line).
    function automatic int draw_piece(input int c, input int r);
        return ((c / 2 + r) % 2) + 1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; left = 1'b0; right = 1'b0; put = 1'b0; new_game = 1'b0;
        rd_col = 3'd0; rd_row = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset state
        expect_v("rst_cursor", S_CUR_A, 0);
        expect_v("rst_player", S_PLY_A, 0);
        expect_v("rst_busy", S_BUSY_A, 0);
        expect_v("rst_inv", S_INV_A, 0);
        expect_v("rst_win", S_WIN_A, 0);
        expect_v("rst_full", S_FULL_A, 0);
        expect_v("rst_dir", S_DIR_A, 0);
        expect_cell("rst_cell", S_CELL_A, 0, 0, 0);
        drain();

        // cursor moves, saturate vs wrap
        repeat (3) press(1'b0, 1'b1, 1'b0);
        expect_v("right3_a", S_CUR_A, 3);
        expect_v("right3_b", S_CUR_B, 3);
        drain();
        repeat (4) press(1'b1, 1'b0, 1'b0);
        expect_v("left4_sat", S_CUR_A, 0);
        expect_v("left4_wrap", S_CUR_B, 6);
        drain();
        press(1'b0, 1'b1, 1'b0);
        expect_v("right_sat", S_CUR_A, 1);
        expect_v("right_wrap", S_CUR_B, 0);
        drain();
        press(1'b1, 1'b1, 1'b0);
        expect_v("both_nomove", S_CUR_A, 1);
        drain();

        // column fill and invalid move
        do_new_game();
        expect_v("ng_cursor", S_CUR_A, 0);
        drain();
        press(1'b0, 1'b1, 1'b1);
        expect_cell("put_right_cell", S_CELL_A, 0, 0, 1);
        expect_v("put_right_cursor", S_CUR_A, 0);
        expect_v("scan_latency", S_LAT_A, 8);
        expect_v("rot_after1", S_PLY_A, 1);
        drain();
        repeat (5) press(1'b0, 1'b0, 1'b1);
        expect_cell("col_top", S_CELL_A, 0, 5, 2);
        expect_v("col_player", S_PLY_A, 0);
        expect_cell("col_b_p2", S_CELL_B, 0, 2, 3);
        drain();
        press(1'b0, 1'b0, 1'b1);
        expect_v("full_col_inv", S_INV_A, 1);
        expect_v("full_col_ply", S_PLY_A, 0);
        expect_cell("full_col_top", S_CELL_A, 0, 5, 2);
        drain();
        press(1'b0, 1'b1, 1'b0);
        cur = 1;
        expect_v("inv_cleared", S_INV_A, 0);
        expect_v("inv_cursor", S_CUR_A, 1);
        drain();

        // horizontal win for player 0
        do_new_game();
        put_at(0); put_at(0); put_at(1); put_at(1); put_at(2); put_at(2);
        expect_v("pre_win", S_WIN_A, 0);
        drain();
        put_at(3);
        expect_v("h_win", S_WIN_A, 1);
        expect_v("h_winner", S_WNR_A, 0);
        expect_v("h_dir", S_DIR_A, 0);
        expect_v("h_col", S_WCOL_A, 3);
        expect_v("h_row", S_WROW_A, 0);
        expect_v("h_full", S_FULL_A, 0);
        drain();
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        expect_cell("done_put_ignored", S_CELL_A, 3, 1, 0);
        expect_v("done_win_held", S_WIN_A, 1);
        expect_v("done_player", S_PLY_A, 0);
        expect_v("done_cursor", S_CUR_A, 3);
        drain();

        // 3-player down-right diagonal for player 1
        do_new_game();
        seq = '{2, 3, 1, 1, 2, 0, 0, 1, 0, 6, 0};
        for (int i = 0; i < seq.size(); i++) begin
            put_at(seq[i]);
            if (i == 0) expect_v("rot_0to1", S_PLY_B, 1);
            if (i == 1) expect_v("rot_1to2", S_PLY_B, 2);
            if (i == 2) expect_v("rot_2to0", S_PLY_B, 0);
            if (i == seq.size() - 2) expect_v("diag_pre", S_WIN_B, 0);
            drain();
        end
        expect_v("diag_win", S_WIN_B, 1);
        expect_v("diag_winner", S_WNR_B, 1);
        expect_v("diag_dir", S_DIR_B, 3);
        drain();

        // full board, no winner
        do_new_game();
        seq.delete();
        for (int k = 0; k < 3; k++) begin
            seq.push_back(0); seq.push_back(6); seq.push_back(6); seq.push_back(0);
        end
        for (int k = 0; k < 6; k++) seq.push_back(1);
        for (int k = 0; k < 3; k++) begin
            seq.push_back(4); seq.push_back(2); seq.push_back(2); seq.push_back(4);
        end
        for (int k = 0; k < 3; k++) begin
            seq.push_back(5); seq.push_back(3); seq.push_back(3); seq.push_back(5);
        end
        for (int i = 0; i < seq.size(); i++) begin
            put_at(seq[i]);
            if (i == seq.size() - 2) begin
                expect_v("full_pre", S_FULL_A, 0);
                drain();
            end
        end
        expect_v("full_panel", S_FULL_A, 1);
        expect_v("full_nowin", S_WIN_A, 0);
        expect_v("full_busy", S_BUSY_A, 0);
        expect_cell("full_c65", S_CELL_A, 6, 5, draw_piece(6, 5));
        expect_cell("full_c32", S_CELL_A, 3, 2, draw_piece(3, 2));
        expect_cell("full_c20", S_CELL_A, 2, 0, draw_piece(2, 0));
        drain();

        // new_game while scanning
        do_new_game();
        press(1'b0, 1'b1, 1'b0);
        cur = 1;
        @(negedge clk);
        put = 1'b1;
        @(negedge clk);
        put = 1'b0;
        expect_v("mid_busy", S_BUSY_A, 1);
        drain();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        expect_v("ng_busy", S_BUSY_A, 0);
        expect_v("ng_player", S_PLY_A, 0);
        expect_v("ng_cur", S_CUR_A, 0);
        expect_v("ng_win", S_WIN_A, 0);
        drain();
        new_game = 1'b0;
        cur = 0;
        expect_cell("ng_cell", S_CELL_A, 1, 0, 0);
        drain();

        // asynchronous reset between edges
        press(1'b0, 1'b1, 1'b0);
        cur = 1;
        press(1'b0, 1'b0, 1'b1);
        expect_v("pre_rst_player", S_PLY_A, 1);
        drain();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        expect_v("arst_cursor", S_CUR_A, 0);
        expect_v("arst_player", S_PLY_A, 0);
        expect_v("arst_busy", S_BUSY_A, 0);
        drain();
        expect_cell("arst_cell", S_CELL_A, 1, 0, 0);
        drain();
        rst = 1'b1;
        cur = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
